time_of_day_counter: RTL and testbench

//  Timekeeping stage directly downstream of the divider: consumes its slow square

---
 rtl/time_of_day_counter.sv | 148 ++++++++++++++
 tb/tb_time_of_day_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// BCD hours:minutes:seconds timekeeper fed by the divider's slow square wave,
// with a two-button set-time state machine. Single clock domain.
module time_of_day_counter #(
  parameter int ticks_per_second = 2,
  parameter bit mode_24h         = 1'b1
) (
  input  logic       input_clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       second_pulse
);

  localparam int sub_w = (ticks_per_second > 1) ? $clog2(ticks_per_second) : 1;
  localparam logic [sub_w-1:0] last_sub = sub_w'(ticks_per_second - 1);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    SET_HOURS   = 2'b01,
    SET_MINUTES = 2'b10
  } state_t;

  state_t           state;
  logic [sub_w-1:0] subsec;
  logic             tick_prev, mode_prev, inc_prev;
  logic             rise_tick, rise_mode, rise_inc;
  logic [8:0]       sec_next, min_next, hour_next;

  // Returns {carry, tens, ones} for a 00..59 BCD field.
  function automatic logic [8:0] next_sixty(input logic [3:0] tens, input logic [3:0] ones);
    logic [8:0] r;
    if (tens == 4'd5 && ones == 4'd9)
      r = 9'h100;
    else if (ones == 4'd9)
      r = {1'b0, tens + 4'd1, 4'd0};
    else
      r = {1'b0, tens, ones + 4'd1};
    return r;
  endfunction

  // Returns {pm, tens, ones}; pm only ever changes on 11->12 in 12-hour mode.
  function automatic logic [8:0] next_hour(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic pm_in);
    logic [8:0] r;
    if (mode_24h) begin
      if (tens == 4'd2 && ones == 4'd3)
        r = {pm_in, 8'h00};
      else if (ones == 4'd9)
        r = {pm_in, tens + 4'd1, 4'd0};
      else
        r = {pm_in, tens, ones + 4'd1};
    end else begin
      if (tens == 4'd1 && ones == 4'd2)
        r = {pm_in, 8'h01};
      else if (tens == 4'd1 && ones == 4'd1)
        r = {~pm_in, 8'h12};
      else if (ones == 4'd9)
        r = {pm_in, tens + 4'd1, 4'd0};
      else
        r = {pm_in, tens, ones + 4'd1};
    end
    return r;
  endfunction

  assign rise_tick = tick_in & ~tick_prev;
  assign rise_mode = mode_btn & ~mode_prev;
  assign rise_inc  = inc_btn & ~inc_prev;
  assign set_state = state;

  always_comb begin
    sec_next  = next_sixty(sec_tens, sec_ones);
    min_next  = next_sixty(min_tens, min_ones);
    hour_next = next_hour(hour_tens, hour_ones, pm);
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state        <= RUN;
      subsec       <= '0;
      tick_prev    <= 1'b1;
      mode_prev    <= 1'b1;
      inc_prev     <= 1'b1;
      second_pulse <= 1'b0;
      pm           <= 1'b0;
      hour_tens    <= mode_24h ? 4'd0 : 4'd1;
      hour_ones    <= mode_24h ? 4'd0 : 4'd2;
      min_tens     <= 4'd0;
      min_ones     <= 4'd0;
      sec_tens     <= 4'd0;
      sec_ones     <= 4'd0;
    end else begin
      tick_prev    <= tick_in;
      mode_prev    <= mode_btn;
      inc_prev     <= inc_btn;
      second_pulse <= 1'b0;
      case (state)
        RUN: begin
          if (rise_tick) begin
            if (subsec == last_sub) begin
              subsec                 <= '0;
              second_pulse           <= 1'b1;
              {sec_tens, sec_ones}   <= sec_next[7:0];
              if (sec_next[8]) begin
                {min_tens, min_ones} <= min_next[7:0];
                if (min_next[8])
                  {pm, hour_tens, hour_ones} <= hour_next;
              end
            end else begin
              subsec <= subsec + 1'b1;
            end
          end
          // A coincident tick still carries into minutes; the clear then overrides seconds.
          if (rise_mode) begin
            state    <= SET_HOURS;
            subsec   <= '0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
        end
        SET_HOURS: begin
          subsec <= '0;
          if (rise_mode)
            state <= SET_MINUTES;
          else if (rise_inc)
            {pm, hour_tens, hour_ones} <= hour_next;
        end
        SET_MINUTES: begin
          subsec <= '0;
          if (rise_mode)
            state <= RUN;
          else if (rise_inc)
            {min_tens, min_ones} <= min_next[7:0];
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: a 24-hour and a 12-hour instance
// share one set of stimulus; expected values are hand-computed constants.
module tb_time_of_day_counter;

  logic clock = 1'b0;
  logic reset, tick_in, mode_btn, inc_btn;

  logic [3:0] ht24, ho24, mt24, mo24, st24, so24;
  logic [3:0] ht12, ho12, mt12, mo12, st12, so12;
  logic       pm24, pm12, pulse24, pulse12;
  logic [1:0] state24, state12;

  logic [23:0] t24, t12;
  assign t24 = {ht24, ho24, mt24, mo24, st24, so24};
  assign t12 = {ht12, ho12, mt12, mo12, st12, so12};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  time_of_day_counter #(.ticks_per_second(2), .mode_24h(1'b1)) dut24 (
    .input_clock(clock), .reset(reset), .tick_in(tick_in), .mode_btn(mode_btn),
    .inc_btn(inc_btn), .hour_tens(ht24), .hour_ones(ho24), .min_tens(mt24),
    .min_ones(mo24), .sec_tens(st24), .sec_ones(so24), .pm(pm24),
    .set_state(state24), .second_pulse(pulse24));

  time_of_day_counter #(.ticks_per_second(2), .mode_24h(1'b0)) dut12 (
    .input_clock(clock), .reset(reset), .tick_in(tick_in), .mode_btn(mode_btn),
    .inc_btn(inc_btn), .hour_tens(ht12), .hour_ones(ho12), .min_tens(mt12),
    .min_ones(mo12), .sec_tens(st12), .sec_ones(so12), .pm(pm12),
    .set_state(state12), .second_pulse(pulse12));

  task automatic check_output(input string tag, input logic [23:0] observed,
                              input logic [23:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clock) tick_in = 1'b1;
    @(negedge clock) tick_in = 1'b0;
  endtask

  task automatic tick_rises(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic press_mode();
    @(negedge clock) mode_btn = 1'b1;
    @(negedge clock) mode_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) inc_btn = 1'b1;
      @(negedge clock) inc_btn = 1'b0;
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock) reset = 1'b1;
    repeat (cycles - 1) @(negedge clock);
    @(negedge clock) reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    tick_in  = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    // Reset with tick_in already high at release
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_output("reset_time24", t24, 24'h000000);
    check_output("reset_time12", t12, 24'h120000);
    check_output("reset_state", {22'd0, state24}, 24'd0);
    check_output("reset_pm_pulse", {22'd0, pm24, pulse24}, 24'd0);
    @(negedge clock);
    check_output("high_tick_no_count", {t24[23:0]}, 24'h000000);
    tick_in = 1'b0;

    // First second needs two rises
    pulse_tick();
    check_output("one_rise_time", t24, 24'h000000);
    check_output("one_rise_pulse", {23'd0, pulse24}, 24'd0);
    pulse_tick();
    check_output("two_rise_time", t24, 24'h000001);
    check_output("two_rise_pulse", {23'd0, pulse24}, 24'd1);
    @(negedge clock);
    check_output("pulse_one_cycle", {23'd0, pulse24}, 24'd0);

    // Set 23:59 and roll over midnight
    press_mode();
    check_output("enter_set_hours", {22'd0, state24}, 24'd1);
    check_output("seconds_cleared", t24, 24'h000000);
    press_inc(23);
    check_output("set_hours_23", t24, 24'h230000);
    press_mode();
    check_output("enter_set_min", {22'd0, state24}, 24'd2);
    press_inc(59);
    check_output("set_min_59", t24, 24'h235900);
    press_mode();
    check_output("back_to_run", {22'd0, state24}, 24'd0);
    tick_rises(118);
    check_output("at_235959", t24, 24'h235959);
    pulse_tick();
    check_output("half_second_no_pulse", {t24[23:0]}, 24'h235959);
    check_output("half_second_pulse0", {23'd0, pulse24}, 24'd0);
    pulse_tick();
    check_output("midnight", t24, 24'h000000);
    check_output("midnight_pulse", {23'd0, pulse24}, 24'd1);
    @(negedge clock);
    check_output("midnight_pulse_clear", {23'd0, pulse24}, 24'd0);

    // Set-mode wrap without carry, ticks frozen
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(37);
    check_output("set_2337", t24, 24'h233700);
    tick_rises(3);
    check_output("frozen_in_set_min", t24, 24'h233700);
    check_output("no_pulse_in_set_min", {23'd0, pulse24}, 24'd0);
    press_mode();
    press_mode();
    check_output("reenter_set_hours", {22'd0, state24}, 24'd1);
    press_inc(1);
    check_output("hour_wrap_23_00", t24, 24'h003700);
    tick_rises(3);
    check_output("frozen_in_set_hours", t24, 24'h003700);
    press_inc(23);
    press_mode();
    press_inc(22);
    check_output("set_2359_again", t24, 24'h235900);
    press_inc(1);
    check_output("min_wrap_59_00", t24, 24'h230000);

    // Simultaneous mode and inc in SET_HOURS
    press_mode();
    press_mode();
    @(negedge clock) begin mode_btn = 1'b1; inc_btn = 1'b1; end
    @(negedge clock) begin mode_btn = 1'b0; inc_btn = 1'b0; end
    check_output("simul_state", {22'd0, state24}, 24'd2);
    check_output("simul_hours_kept", t24, 24'h230000);
    press_inc(1);
    check_output("simul_then_inc_min", t24, 24'h230100);

    // Reset during SET_MINUTES
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check_output("midset_reset_state", {22'd0, state24}, 24'd0);
    check_output("midset_reset_time24", t24, 24'h000000);
    check_output("midset_reset_time12", t12, 24'h120000);
    reset = 1'b0;

    // 12-hour instance: 11:59:59 -> 12:00:00 pm, 12:59:59 -> 01:00:00
    apply_reset(3);
    press_mode();
    press_inc(1);
    check_output("h12_12_to_01", {t12[23:0]}, 24'h010000);
    press_inc(10);
    check_output("h12_set_11", t12, 24'h110000);
    check_output("h12_set_11_pm", {23'd0, pm12}, 24'd0);
    press_mode();
    press_inc(59);
    press_mode();
    tick_rises(118);
    check_output("h12_at_115959", t12, 24'h115959);
    tick_rises(2);
    check_output("h12_noon", t12, 24'h120000);
    check_output("h12_noon_pm", {23'd0, pm12}, 24'd1);
    check_output("h12_noon_pulse", {23'd0, pulse12}, 24'd1);
    check_output("h24_pm_stays_0", {23'd0, pm24}, 24'd0);
    press_mode();
    press_mode();
    press_inc(59);
    press_mode();
    check_output("h12_set_1259", t12, 24'h125900);
    tick_rises(120);
    check_output("h12_one_pm", t12, 24'h010000);
    check_output("h12_one_pm_flag", {23'd0, pm12}, 24'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
